// File: rtl/mul_sched_pkg.sv
// Shared types, constants and round-robin helper for the Booth multiplier scheduler.
package mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BOOTH_ITER = 33;
    localparam int Q_W        = 33;
    localparam int M_W        = 9;

    // Returns the first asserted request at or after ptr, wrapping within n clients.
    function automatic logic [2:0] rr_next(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int unsigned n);
        logic [2:0] win;
        logic       found;
        logic [3:0] idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'(n))
                idx = idx - 4'(n);
            if (!found && (i < int'(n)) && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/booth_step_dp.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic shift of {A,Q,Q_1}.
module booth_step_dp
    import mul_sched_pkg::*;
(
    input  logic [Q_W-1:0] i_a,
    input  logic [Q_W-1:0] i_q,
    input  logic           i_q1,
    input  logic [Q_W-1:0] i_m,
    output logic [Q_W-1:0] o_a,
    output logic [Q_W-1:0] o_q,
    output logic           o_q1
);

    logic [Q_W-1:0] w_sum;

    always_comb begin
        w_sum = i_a;
        case ({i_q[0], i_q1})
            2'b01:   w_sum = i_a + i_m;
            2'b10:   w_sum = i_a + ~i_m + 33'd1;
            default: w_sum = i_a;
        endcase
    end

    assign o_a  = {w_sum[Q_W-1], w_sum[Q_W-1:1]};
    assign o_q  = {w_sum[0], i_q[Q_W-1:1]};
    assign o_q1 = i_q[0];

endmodule

// File: rtl/booth_mul_scheduler.sv
// Round-robin arbiter and start/busy/done sequencer wrapped around a shared Booth multiplier step.
module booth_mul_scheduler
    import mul_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int PROD_W  = 42
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ*32-1:0] i_q_in,
    input  logic [NUM_REQ*9-1:0]  i_m_in,
    input  logic [NUM_REQ-1:0]    i_sam,
    input  logic                  i_flush,
    output logic [NUM_REQ-1:0]    o_grant,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ID_W-1:0]       o_done_id,
    output logic [PROD_W-1:0]     o_product
);

    state_t              r_state;
    state_t              w_next_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_done;
    logic [ID_W-1:0]     r_done_id;
    logic [PROD_W-1:0]   r_product;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_winner;
    logic [Q_W-1:0]      r_a;
    logic [Q_W-1:0]      r_q;
    logic                r_q1;
    logic [Q_W-1:0]      r_m;
    logic [5:0]          r_count;

    logic [ID_W-1:0]     w_pick;
    logic [31:0]         w_q_sel;
    logic [M_W-1:0]      w_m_sel;
    logic                w_sam_sel;
    logic [Q_W-1:0]      w_a_nxt;
    logic [Q_W-1:0]      w_q_nxt;
    logic                w_q1_nxt;

    assign w_pick    = ID_W'(rr_next(8'(i_req), 3'(r_ptr), NUM_REQ));
    assign w_q_sel   = i_q_in[32*w_pick +: 32];
    assign w_m_sel   = i_m_in[9*w_pick +: 9];
    assign w_sam_sel = i_sam[w_pick];

    booth_step_dp u_step (
        .i_a  (r_a),
        .i_q  (r_q),
        .i_q1 (r_q1),
        .i_m  (r_m),
        .o_a  (w_a_nxt),
        .o_q  (w_q_nxt),
        .o_q1 (w_q1_nxt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // A pending request always beats flush in IDLE; flush only aborts RUN/DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (|i_req) w_next_state = RUN;
            RUN: begin
                if (i_flush)
                    w_next_state = IDLE;
                else if (r_count == 6'd1)
                    w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant   <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_product <= '0;
            r_ptr     <= '0;
            r_winner  <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_m       <= '0;
            r_count   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_grant  <= NUM_REQ'(1) << w_pick;
                        r_winner <= w_pick;
                        r_ptr    <= (w_pick == ID_W'(NUM_REQ - 1)) ? '0 : w_pick + 1'b1;
                        r_q      <= {w_sam_sel & w_q_sel[31], w_q_sel};
                        r_m      <= {{(Q_W - M_W){w_m_sel[M_W-1]}}, w_m_sel};
                        r_a      <= '0;
                        r_q1     <= 1'b0;
                        r_count  <= 6'(BOOTH_ITER);
                    end
                end
                RUN: begin
                    if (i_flush) begin
                        r_grant <= '0;
                    end else begin
                        r_a     <= w_a_nxt;
                        r_q     <= w_q_nxt;
                        r_q1    <= w_q1_nxt;
                        r_count <= r_count - 6'd1;
                    end
                end
                DONE: begin
                    r_grant <= '0;
                    if (!i_flush) begin
                        r_done    <= 1'b1;
                        r_done_id <= r_winner;
                        r_product <= PROD_W'({r_a, r_q});
                    end
                end
                default: r_grant <= '0;
            endcase
        end
    end

    assign o_grant   = r_grant;
    assign o_busy    = (r_state != IDLE);
    assign o_done    = r_done;
    assign o_done_id = r_done_id;
    assign o_product = r_product;

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Directed self-checking bench for booth_mul_scheduler using immediate assertions.
module tb_booth_mul_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int PROD_W  = 42;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*32-1:0] q_in;
    logic [NUM_REQ*9-1:0]  m_in;
    logic [NUM_REQ-1:0]    sam;
    logic                  flush;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;
    logic                  done;
    logic [ID_W-1:0]       done_id;
    logic [PROD_W-1:0]     product;

    int n_checks   = 0;
    int n_fail     = 0;
    int done_seen  = 0;
    int overlap    = 0;

    booth_mul_scheduler #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .PROD_W  (PROD_W)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_q_in    (q_in),
        .i_m_in    (m_in),
        .i_sam     (sam),
        .i_flush   (flush),
        .o_grant   (grant),
        .o_busy    (busy),
        .o_done    (done),
        .o_done_id (done_id),
        .o_product (product)
    );

    always #5 clk = ~clk;

    // Done pulses and grant overlap are watched on the falling edge, clear of the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if ($countones(grant) > 1) overlap++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, observed hang, required finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int id, input logic [31:0] q, input logic [8:0] m, input logic s);
        q_in[id*32 +: 32] = q;
        m_in[id*9 +: 9]   = m;
        sam[id]           = s;
        req[id]           = 1'b1;
    endtask

    // Waits (bounded) for done; returns the number of edges counted including the ones already taken.
    task automatic waitDone(inout int edges);
        while (done !== 1'b1 && edges < 60) begin
            tick();
            edges++;
        end
    endtask

    task automatic runOp(input string tag, input int id, input logic [31:0] q, input logic [8:0] m,
                         input logic s, input logic [PROD_W-1:0] exp_prod);
        int edges;
        applyStimulus(id, q, m, s);
        tick();
        edges = 1;
        checkOutput({tag, ".grant"}, 64'(grant), 64'(1) << id);
        checkOutput({tag, ".busy"}, 64'(busy), 64'd1);
        waitDone(edges);
        req[id] = 1'b0;
        checkOutput({tag, ".latency"}, 64'(edges), 64'd35);
        checkOutput({tag, ".done_id"}, 64'(done_id), 64'(id));
        checkOutput({tag, ".product"}, 64'(product), 64'(exp_prod));
        checkOutput({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        tick();
        checkOutput({tag, ".done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int edges;
        int seen_before;

        rst   = 1'b1;
        req   = '0;
        q_in  = '0;
        m_in  = '0;
        sam   = '0;
        flush = 1'b0;
        #2;
        checkOutput("reset.grant", 64'(grant), 64'd0);
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.done_id", 64'(done_id), 64'd0);
        checkOutput("reset.product", 64'(product), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("idle.busy", 64'(busy), 64'd0);

        runOp("t1_5x3", 0, 32'd5, 9'd3, 1'b0, 42'd15);
        runOp("t2_m1xm1", 1, 32'hFFFF_FFFF, 9'h1FF, 1'b1, 42'd1);
        runOp("t3_unsigned", 2, 32'hFFFF_FFFF, 9'h0FF, 1'b0, 42'h0FEFFFFFF01);
        runOp("t4_minmin", 3, 32'h8000_0000, 9'h100, 1'b1, 42'h08000000000);

        // Clients 0 and 1 contend; pointer is back at 0 after the four single ops.
        applyStimulus(0, 32'd11, 9'd4, 1'b0);
        applyStimulus(1, 32'd6, 9'h1FD, 1'b1);
        tick();
        edges = 1;
        checkOutput("rr1.grant", 64'(grant), 64'b0001);
        waitDone(edges);
        req[0] = 1'b0;
        checkOutput("rr1.latency", 64'(edges), 64'd35);
        checkOutput("rr1.done_id", 64'(done_id), 64'd0);
        checkOutput("rr1.product", 64'(product), 64'd44);
        tick();
        edges = 1;
        checkOutput("rr2.grant", 64'(grant), 64'b0010);
        waitDone(edges);
        req[1] = 1'b0;
        checkOutput("rr2.latency", 64'(edges), 64'd35);
        checkOutput("rr2.done_id", 64'(done_id), 64'd1);
        checkOutput("rr2.product", 64'(product), 64'(42'h3FFFFFFFFEE));
        tick();
        checkOutput("rr.no_overlap", 64'(overlap), 64'd0);
        runOp("rr3_wrap", 0, 32'd1, 9'h07F, 1'b0, 42'd127);

        // Flush arriving together with a new request in IDLE must not block the grant.
        applyStimulus(2, 32'd9, 9'd10, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        edges = 1;
        checkOutput("flushreq.grant", 64'(grant), 64'b0100);
        waitDone(edges);
        req[2] = 1'b0;
        checkOutput("flushreq.latency", 64'(edges), 64'd35);
        checkOutput("flushreq.product", 64'(product), 64'd90);
        tick();

        // Asynchronous reset part-way through a run.
        applyStimulus(1, 32'd1000, 9'd7, 1'b0);
        tick();
        repeat (16) tick();
        checkOutput("midrst.busy_before", 64'(busy), 64'd1);
        seen_before = done_seen;
        rst    = 1'b1;
        req[1] = 1'b0;
        #1;
        checkOutput("midrst.grant", 64'(grant), 64'd0);
        checkOutput("midrst.busy", 64'(busy), 64'd0);
        checkOutput("midrst.done", 64'(done), 64'd0);
        checkOutput("midrst.product", 64'(product), 64'd0);
        tick();
        rst = 1'b0;
        repeat (40) tick();
        checkOutput("midrst.no_done", 64'(done_seen), 64'(seen_before));

        runOp("t5_3xm2", 3, 32'd3, 9'h1FE, 1'b0, 42'h3FFFFFFFFFA);

        // Flush a fresh operation around count 10: no done, product keeps the last result.
        applyStimulus(1, 32'd100, 9'd2, 1'b0);
        tick();
        repeat (22) tick();
        seen_before = done_seen;
        flush  = 1'b1;
        req[1] = 1'b0;
        tick();
        flush = 1'b0;
        checkOutput("flush.busy", 64'(busy), 64'd0);
        checkOutput("flush.grant", 64'(grant), 64'd0);
        repeat (40) tick();
        checkOutput("flush.no_done", 64'(done_seen), 64'(seen_before));
        checkOutput("flush.product_held", 64'(product), 64'(42'h3FFFFFFFFFA));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
